sr595_rx: RTL and testbench
===========================

// Module: sr595_rx
// PURPOSE
//  Clocked receiver for the 74HC595 serial display link (SHCP/STCP/DS/OE): the other end of ctrl_74hc595.
//  Oversamples the link, rebuilds the shift/storage registers of a WIDTH-bit 595 chain and presents the
//  latched word in parallel. Serves as an in-fabric link monitor and as the bench-side decoder for display checks.
// PARAMETERS
//  WIDTH            12  chain length in bits; default matches the {segments[7:0], anodes[3:0]} frame
//  SYNC_STAGES      2   synchronizer flops per input (>=2)
//  ANODE_ACTIVE_LOW 1   anode polarity, used only by the digit-capture option
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous reset, active-low
//  i_shcp         in   1        shift clock from link; bit shifts on rising edge
//  i_stcp         in   1        storage clock from link; latches on rising edge
//  i_ds           in   1        serial data
//  i_oe           in   1        output enable from link, active-low
//  o_data         out  WIDTH    storage register contents
//  o_valid        out  1        1-cycle pulse when o_data updates
//  o_frame_err    out  1        1-cycle pulse with o_valid if shift count since last latch != WIDTH
//  o_oe           out  1        synchronized output enable, active-high (1 = display driven)
//  o_digits       out  32       [RX_DIGIT_CAPTURE_EN only] per-digit segments, digit i at [8*i+:8]
//  o_digits_valid out  1        [RX_DIGIT_CAPTURE_EN only] high once all 4 digits captured since reset
// BEHAVIOUR
//  - Reset: shift reg, o_data, o_digits = 0; o_valid, o_frame_err, o_digits_valid = 0; o_oe = 0; bit count = 0.
//  - All inputs pass SYNC_STAGES flops, then a 1-flop edge detector. Link edge at cycle n acts at
//    n+SYNC_STAGES+1. Link high/low phases must each last >= 2 clk cycles; shorter pulses are not guaranteed.
//  - SHCP rise: sr <= {sr[WIDTH-2:0], ds_sync}; DS sampled in the same synchronized cycle as the edge.
//    First bit shifted lands in o_data[WIDTH-1] after WIDTH shifts (MSB first).
//  - Bit count increments per SHCP rise, saturating at 255; cleared on STCP rise.
//  - STCP rise: o_data <= sr; o_valid = 1 for one cycle; o_frame_err = (count != WIDTH) in the same cycle.
//  - SHCP and STCP rising in the same synchronized cycle: storage takes sr value BEFORE that shift
//    (tied-clock 595 behaviour); the shift still happens; count restarts at 1.
//  - o_oe = ~i_oe_sync; does not gate o_data. Falling edges of SHCP/STCP have no effect.
//  - Async reset mid-frame discards partial shift; first frame after reset can flag o_frame_err.
// CONFIGURATION
//  RX_DIGIT_CAPTURE_EN defined: on each o_valid, treat o_data as {seg[7:0], an[3:0]}; active anodes per
//    ANODE_ACTIVE_LOW; if exactly one anode active (index i), o_digits[8*i+:8] <= seg (1 cycle after o_valid);
//    zero or multiple active anodes: no update. o_digits_valid sets after digits 0..3 each captured once,
//    stays high until reset. Requires WIDTH == 12 (elaboration error otherwise).
//  Undefined: o_digits / o_digits_valid ports and logic absent.
// STRUCTURE
//  - Package sr595_pkg: SR595_DIGITS=4, SR595_SEG_W=8, SR595_AN_W=4, SR595_CNT_W=8 constants.
//  - Sub-module sync_edge (SYNC_STAGES synchronizer + rise detector), instantiated for SHCP, STCP;
//    DS and OE use its synchronized output only, keeping all four equally delayed.
// TESTING
//  1. Send 12 bits 0xA5C MSB first, then STCP -> o_data=0xA5C, single o_valid, o_frame_err=0.
//  2. Send 11 bits then STCP -> o_valid with o_frame_err=1; o_data = prior sr shifted 11 places.
//  3. SHCP+STCP rising together after 12-bit frame 0x123 then 12 bits 0x456 -> o_data=0x123 on tied edge.
//  4. Assert rst_n=0 after 6 of 12 bits, resume full 0xFFF frame -> o_data=0xFFF, err=0, no stale bits.
//  5. Toggle i_oe 1->0->1 -> o_oe follows inverted after SYNC_STAGES+1 cycles; o_data unchanged.
//  6. RX_DIGIT_CAPTURE_EN: frames {0xC0,0xE},{0xF9,0xD},{0xA4,0xB},{0x99,0x7} -> o_digits=0x99A4F9C0,
//     o_digits_valid=1; frame {0x00,0xC} (two anodes) leaves o_digits unchanged.

Source files
------------

// File: rtl/sr595_pkg.sv
// Shared constants and helpers for the 74HC595 link receiver.
// Digit capture is built only when RX_DIGIT_CAPTURE_EN is defined.
package sr595_pkg;

  localparam int SR595_DIGITS = 4;
  localparam int SR595_SEG_W  = 8;
  localparam int SR595_AN_W   = 4;
  localparam int SR595_CNT_W  = 8;

  localparam logic [SR595_CNT_W-1:0] SR595_CNT_MAX = '1;

  function automatic logic [SR595_CNT_W-1:0] sat_inc(
    input logic [SR595_CNT_W-1:0] c
  );
    return (c == SR595_CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sr595_rx_sync_edge.sv
// Multi-flop input synchronizer followed by a one-flop rise detector.
// Macro RX_DIGIT_CAPTURE_EN does not affect this file.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_edge: STAGES must be >= 2");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/sr595_rx.sv
// Oversampling receiver that rebuilds a 74HC595 chain from SHCP/STCP/DS/OE.
// Define RX_DIGIT_CAPTURE_EN to add per-digit segment capture (WIDTH == 12).
module sr595_rx
  import sr595_pkg::*;
#(
  parameter int WIDTH            = 12,
  parameter int SYNC_STAGES      = 2,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_shcp,
  input  logic             i_stcp,
  input  logic             i_ds,
  input  logic             i_oe,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_oe
`ifdef RX_DIGIT_CAPTURE_EN
  ,
  output logic [31:0]      o_digits,
  output logic             o_digits_valid
`endif
);

  localparam logic [SR595_CNT_W-1:0] WIDTH_CNT =
    SR595_CNT_W'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("sr595_rx: WIDTH must be >= 2");
  end

  if (ANODE_ACTIVE_LOW != 0 && ANODE_ACTIVE_LOW != 1) begin : g_bad_pol
    $error("sr595_rx: ANODE_ACTIVE_LOW must be 0 or 1");
  end

  logic shcp_s, shcp_rise;
  logic stcp_s, stcp_rise;
  logic ds_s, ds_rise_unused;
  logic oe_s, oe_rise_unused;
  logic shcp_s_unused, stcp_s_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_shcp (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (i_shcp),
    .sync_o (shcp_s),
    .rise_o (shcp_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_stcp (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (i_stcp),
    .sync_o (stcp_s),
    .rise_o (stcp_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ds (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (i_ds),
    .sync_o (ds_s),
    .rise_o (ds_rise_unused)
  );

  // OE idles disabled so o_oe stays low while the flops fill after reset.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_oe (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (i_oe),
    .sync_o (oe_s),
    .rise_o (oe_rise_unused)
  );

  assign shcp_s_unused = shcp_s;
  assign stcp_s_unused = stcp_s;

  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SR595_CNT_W-1:0] cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   oe_q, oe_d;

  // Storage samples sr_q, i.e. the value before a coincident shift.
  always_comb begin
    sr_d    = sr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    oe_d    = ~oe_s;
    if (shcp_rise) begin
      sr_d  = {sr_q[WIDTH-2:0], ds_s};
      cnt_d = sat_inc(cnt_q);
    end
    if (stcp_rise) begin
      data_d  = sr_q;
      valid_d = 1'b1;
      err_d   = (cnt_q != WIDTH_CNT);
      cnt_d   = shcp_rise ? SR595_CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;
  assign o_oe        = oe_q;

`ifdef RX_DIGIT_CAPTURE_EN
  if (WIDTH != 12) begin : g_bad_dig
    $error("sr595_rx: digit capture requires WIDTH == 12");
  end

  logic [SR595_SEG_W-1:0]  seg;
  logic [SR595_AN_W-1:0]   an_act;
  logic [31:0]             dig_q, dig_d;
  logic [SR595_DIGITS-1:0] seen_q, seen_d;
  logic                    dval_q, dval_d;

  assign seg    = data_q[SR595_AN_W +: SR595_SEG_W];
  assign an_act = (ANODE_ACTIVE_LOW != 0) ?
                  ~data_q[SR595_AN_W-1:0] :
                  data_q[SR595_AN_W-1:0];

  always_comb begin
    dig_d  = dig_q;
    seen_d = seen_q;
    if (valid_q && $onehot(an_act)) begin
      for (int i = 0; i < SR595_DIGITS; i++) begin
        if (an_act[i]) begin
          dig_d[SR595_SEG_W*i +: SR595_SEG_W] = seg;
        end
      end
      seen_d = seen_q | an_act;
    end
    dval_d = dval_q | (&seen_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q  <= '0;
      seen_q <= '0;
      dval_q <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      seen_q <= seen_d;
      dval_q <= dval_d;
    end
  end

  assign o_digits       = dig_q;
  assign o_digits_valid = dval_q;
`endif

endmodule

// File: tb/tb_sr595_rx.sv
// Directed bench for sr595_rx: frames, short frames, tied clocks, reset, OE.
// Digit-capture steps run when RX_DIGIT_CAPTURE_EN is defined.
`timescale 1ns/1ps
module tb_sr595_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_shcp, i_stcp, i_ds, i_oe;
  logic [11:0] o_data;
  logic        o_valid, o_frame_err, o_oe;
`ifdef RX_DIGIT_CAPTURE_EN
  logic [31:0] o_digits;
  logic        o_digits_valid;
`endif

  int tests  = 0;
  int failed = 0;
  int vcount = 0;

  always #5 clk = ~clk;

  sr595_rx #(
    .WIDTH(12),
    .SYNC_STAGES(2),
    .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_shcp         (i_shcp),
    .i_stcp         (i_stcp),
    .i_ds           (i_ds),
    .i_oe           (i_oe),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_frame_err    (o_frame_err),
    .o_oe           (o_oe)
`ifdef RX_DIGIT_CAPTURE_EN
    ,
    .o_digits       (o_digits),
    .o_digits_valid (o_digits_valid)
`endif
  );

  always @(negedge clk) if (o_valid) vcount++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    i_ds = b;
    cyc(2);
    i_shcp = 1'b1;
    cyc(2);
    i_shcp = 1'b0;
    cyc(2);
  endtask

  task automatic send(input logic [11:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic do_latch(input string tag, input logic tied,
                          output logic [11:0] d, output logic e);
    int v0;
    bit seen;
    v0   = vcount;
    seen = 1'b0;
    d    = '0;
    e    = 1'b0;
    i_stcp = 1'b1;
    if (tied) i_shcp = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (o_valid) begin
        seen = 1'b1;
        d    = o_data;
        e    = o_frame_err;
      end
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    cyc(2);
    i_stcp = 1'b0;
    i_shcp = 1'b0;
    cyc(4);
    check({tag, "_valid_once"}, 32'(vcount - v0), 32'd1);
  endtask

  initial begin
    logic [11:0] d;
    logic        e;
    rst_n  = 1'b0;
    i_shcp = 1'b0;
    i_stcp = 1'b0;
    i_ds   = 1'b0;
    i_oe   = 1'b1;
    cyc(3);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_err", 32'(o_frame_err), 32'h0);
    check("rst_oe", 32'(o_oe), 32'h0);
`ifdef RX_DIGIT_CAPTURE_EN
    check("rst_digits", o_digits, 32'h0);
    check("rst_dvalid", 32'(o_digits_valid), 32'h0);
`endif
    rst_n = 1'b1;
    cyc(4);
    check("idle_oe", 32'(o_oe), 32'h0);

    send(12'hA5C, 12);
    do_latch("f1", 1'b0, d, e);
    check("f1_data", 32'(d), 32'hA5C);
    check("f1_err", 32'(e), 32'h0);

    // 11 bits: MSB is the old LSB of 0xA5C (0)
    send(12'h6B3, 11);
    do_latch("short1", 1'b0, d, e);
    check("short1_data", 32'(d), 32'h6B3);
    check("short1_err", 32'(e), 32'h1);

    // old LSB of 0x6B3 is 1
    send(12'h000, 11);
    do_latch("short2", 1'b0, d, e);
    check("short2_data", 32'(d), 32'h800);
    check("short2_err", 32'(e), 32'h1);

    send(12'h123, 12);
    i_ds = 1'b0;
    cyc(2);
    do_latch("tied", 1'b1, d, e);
    check("tied_data", 32'(d), 32'h123);
    check("tied_err", 32'(e), 32'h0);
    send(12'h456, 11);
    do_latch("after_tied", 1'b0, d, e);
    check("after_tied_data", 32'(d), 32'h456);
    check("after_tied_err", 32'(e), 32'h0);

    send(12'hFFF, 6);
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_data", 32'(o_data), 32'h0);
    check("mid_rst_valid", 32'(o_valid), 32'h0);
    rst_n = 1'b1;
    cyc(4);
    send(12'hFFF, 12);
    do_latch("post_rst", 1'b0, d, e);
    check("post_rst_data", 32'(d), 32'hFFF);
    check("post_rst_err", 32'(e), 32'h0);

    i_oe = 1'b0;
    cyc(2);
    check("oe_on_early", 32'(o_oe), 32'h0);
    cyc(1);
    check("oe_on", 32'(o_oe), 32'h1);
    check("oe_data_hold", 32'(o_data), 32'hFFF);
    i_oe = 1'b1;
    cyc(2);
    check("oe_off_early", 32'(o_oe), 32'h1);
    cyc(1);
    check("oe_off", 32'(o_oe), 32'h0);
    check("oe_data_hold2", 32'(o_data), 32'hFFF);

`ifdef RX_DIGIT_CAPTURE_EN
    check("dig_pre_valid", 32'(o_digits_valid), 32'h0);
    send({8'hC0, 4'hE}, 12);
    do_latch("dig0", 1'b0, d, e);
    check("dig0_val", o_digits, 32'h0000_00C0);
    send({8'hF9, 4'hD}, 12);
    do_latch("dig1", 1'b0, d, e);
    send({8'hA4, 4'hB}, 12);
    do_latch("dig2", 1'b0, d, e);
    check("dig_3of4_valid", 32'(o_digits_valid), 32'h0);
    send({8'h99, 4'h7}, 12);
    do_latch("dig3", 1'b0, d, e);
    check("dig_all", o_digits, 32'h99A4_F9C0);
    check("dig_valid", 32'(o_digits_valid), 32'h1);
    send({8'h00, 4'hC}, 12);
    do_latch("dig_multi", 1'b0, d, e);
    check("dig_multi_hold", o_digits, 32'h99A4_F9C0);
    check("dig_multi_valid", 32'(o_digits_valid), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
